// File: rtl/rx_depacketizer_pkg.sv
// rtl/rx_depacketizer_pkg.sv - shared Rx/Tx packet constants, FSM encoding and error bit indices
package rx_depacketizer_pkg;

    localparam logic [15:0] SYNC_WORD_DEF = 16'hEB90;
    localparam int          MAX_LEN_DEF   = 512;
    localparam int          TIMEOUT_DEF   = 64;
    localparam logic [7:0]  CSUM_SEED     = 8'h00;

    localparam int ERR_CSUM = 0;
    localparam int ERR_LEN  = 1;
    localparam int ERR_OVF  = 2;

    typedef enum logic [2:0] {
        ST_HUNT    = 3'd0,
        ST_LEN_HI  = 3'd1,
        ST_LEN_LO  = 3'd2,
        ST_PAYLOAD = 3'd3,
        ST_CHECK   = 3'd4
    } depkt_state_e;

endpackage

// File: rtl/depkt_sync_hunter.sv
// rtl/depkt_sync_hunter.sv - byte-aligned sync word detector with overlapping match support
module depkt_sync_hunter
    import rx_depacketizer_pkg::*;
#(
    parameter logic [15:0] SYNC_WORD = SYNC_WORD_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en_i,
    input  logic [7:0] byte_i,
    output logic       match_o
);

    logic [7:0] prev_q, prev_d;

    // Comparing against the incoming byte lets a byte that breaks a partial match start a new one.
    assign match_o = en_i && ({prev_q, byte_i} == SYNC_WORD);

    always_comb begin
        prev_d = prev_q;
        if (en_i) begin
            prev_d = match_o ? 8'h00 : byte_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q <= 8'h00;
        end else begin
            prev_q <= prev_d;
        end
    end

endmodule

// File: rtl/rx_depacketizer.sv
// rtl/rx_depacketizer.sv - sync hunt, length parse, payload forward and XOR checksum check
// Optional input-idle watchdog enabled by DEPKT_TIMEOUT_EN.
module rx_depacketizer
    import rx_depacketizer_pkg::*;
#(
    parameter logic [15:0] SYNC_WORD = SYNC_WORD_DEF,
    parameter int          MAX_LEN   = MAX_LEN_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clk_enable,
    input  logic [7:0]  I_tdata,
    input  logic        I_tvalid,
    output logic [7:0]  O_tdata,
    output logic        O_tvalid,
    input  logic        O_tready,
    output logic        O_tlast,
    output logic        O_tuser,
    output logic [15:0] payload_length,
    output logic        pkt_done,
    output logic [2:0]  err_pulse
);

    depkt_state_e state_q, state_d;
    logic [7:0]  len_hi_q, len_hi_d, csum_q, csum_d, hold_q, hold_d, out_data_q, out_data_d;
    logic [15:0] len_q, len_d, cnt_q, cnt_d, new_len;
    logic        out_valid_q, out_valid_d, out_last_q, out_last_d, out_user_q, out_user_d;
    logic        done_q, done_d;
    logic [2:0]  err_q, err_d;
    logic        beat, xfer, out_free, hunt_match, move, move_last, move_user;
`ifdef DEPKT_TIMEOUT_EN
    logic [15:0] wdog_q, wdog_d;
`endif

    assign beat     = clk_enable && I_tvalid;
    assign xfer     = clk_enable && out_valid_q && O_tready;
    assign out_free = !out_valid_q || xfer;
    assign new_len  = {len_hi_q, I_tdata};

    depkt_sync_hunter #(.SYNC_WORD(SYNC_WORD)) u_hunter (
        .clk     (clk),
        .rst_n   (rst_n),
        .en_i    (beat && (state_q == ST_HUNT)),
        .byte_i  (I_tdata),
        .match_o (hunt_match)
    );

    always_comb begin
        state_d     = state_q;
        len_hi_d    = len_hi_q;
        len_d       = len_q;
        csum_d      = csum_q;
        cnt_d       = cnt_q;
        hold_d      = hold_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        out_user_d  = out_user_q;
        done_d      = 1'b0;
        err_d       = 3'b000;
        move        = 1'b0;
        move_last   = 1'b0;
        move_user   = 1'b0;
`ifdef DEPKT_TIMEOUT_EN
        wdog_d      = wdog_q;
`endif
        if (xfer) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            ST_HUNT: begin
                if (hunt_match) state_d = ST_LEN_HI;
            end
            ST_LEN_HI: begin
                if (beat) begin
                    len_hi_d = I_tdata;
                    csum_d   = CSUM_SEED ^ I_tdata;
                    state_d  = ST_LEN_LO;
                end
            end
            ST_LEN_LO: begin
                if (beat) begin
                    len_d  = new_len;
                    csum_d = csum_q ^ I_tdata;
                    if (new_len == 16'd0 || new_len > 16'(MAX_LEN)) begin
                        err_d[ERR_LEN] = 1'b1;
                        state_d        = ST_HUNT;
                    end else begin
                        cnt_d   = 16'd0;
                        state_d = ST_PAYLOAD;
                    end
                end
            end
            ST_PAYLOAD: begin
                if (beat) begin
                    csum_d = csum_q ^ I_tdata;
                    hold_d = I_tdata;
                    cnt_d  = cnt_q + 16'd1;
                    move   = (cnt_q != 16'd0);
                    if (cnt_q == len_q - 16'd1) state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (beat) begin
                    move      = 1'b1;
                    move_last = 1'b1;
                    move_user = (csum_q != I_tdata);
                    state_d   = ST_HUNT;
                end
            end
            default: state_d = ST_HUNT;
        endcase

        // A blocked move means the source cannot be stalled: abort and mark the pending beat bad.
        if (move) begin
            if (out_free) begin
                out_data_d  = hold_q;
                out_valid_d = 1'b1;
                out_last_d  = move_last;
                out_user_d  = move_user;
                if (move_last) begin
                    err_d[ERR_CSUM] = move_user;
                    done_d          = !move_user;
                end
            end else begin
                out_last_d     = 1'b1;
                out_user_d     = 1'b1;
                err_d[ERR_OVF] = 1'b1;
                state_d        = ST_HUNT;
            end
        end

`ifdef DEPKT_TIMEOUT_EN
        if (state_q == ST_HUNT || beat) begin
            wdog_d = 16'd0;
        end else if (clk_enable) begin
            if (wdog_q == 16'(TIMEOUT_DEF - 1)) begin
                wdog_d         = 16'd0;
                err_d[ERR_LEN] = 1'b1;
                state_d        = ST_HUNT;
                if (out_valid_q && !xfer && !out_last_q) begin
                    out_last_d = 1'b1;
                    out_user_d = 1'b1;
                end
            end else begin
                wdog_d = wdog_q + 16'd1;
            end
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_HUNT;
            len_hi_q    <= 8'h00;
            len_q       <= 16'd0;
            csum_q      <= 8'h00;
            cnt_q       <= 16'd0;
            hold_q      <= 8'h00;
            out_data_q  <= 8'h00;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_user_q  <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 3'b000;
        end else begin
            state_q     <= state_d;
            len_hi_q    <= len_hi_d;
            len_q       <= len_d;
            csum_q      <= csum_d;
            cnt_q       <= cnt_d;
            hold_q      <= hold_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_user_q  <= out_user_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

`ifdef DEPKT_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdog_q <= 16'd0;
        end else begin
            wdog_q <= wdog_d;
        end
    end
`endif

    assign O_tdata        = out_data_q;
    assign O_tvalid       = out_valid_q;
    assign O_tlast        = out_last_q;
    assign O_tuser        = out_user_q;
    assign payload_length = len_q;
    assign pkt_done       = done_q;
    assign err_pulse      = err_q;

endmodule
